// File: rtl/railway_pkg.sv
// Shared types and default timing for the level-crossing track sensor block.
package railway_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned CLEAR_HOLD_DEF      = 8;
    localparam int unsigned GATE_TIMEOUT_DEF    = 64;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OCCUPIED,
        ST_CLEARING,
        ST_FAULT
    } rail_state_e;

    // Counter width able to hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Debounces one raw track sensor and pulses rise for one cycle when the
// filtered level goes 0->1.
module sensor_debounce
    import railway_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          level;
    logic [CW-1:0] cnt;

    // Count consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            rise <= 1'b0;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= raw;
                rise  <= raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/track_sensor_tx.sv
// Track occupancy tracker: counts trains between the approach and exit
// sensors and requests the crossing gate via SW1, with gate-timeout faulting.
module track_sensor_tx
    import railway_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CLEAR_HOLD      = CLEAR_HOLD_DEF,
    parameter int unsigned GATE_TIMEOUT    = GATE_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             S_IN,
    input  logic             S_OUT,
    input  logic             GATE_CLOSED,
    output logic             SW1,
    output logic             LED3,
    output logic [CNT_W-1:0] TRAIN_CNT
);

    localparam int unsigned TW = cnt_width(GATE_TIMEOUT);
    localparam int unsigned HW = cnt_width(CLEAR_HOLD);
    localparam logic [TW-1:0] TO_LAST   = TW'(GATE_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLEAR_HOLD - 1);

    rail_state_e      state, state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [TW-1:0]    timer, timer_d;
    logic [HW-1:0]    hold, hold_d;
    logic             gate_ok, gate_ok_d;
    logic             entry_ev, exit_ev;
    logic             fault_ev;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_in (
        .clk   (clk),
        .reset (reset),
        .raw   (S_IN),
        .rise  (entry_ev)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_out (
        .clk   (clk),
        .reset (reset),
        .raw   (S_OUT),
        .rise  (exit_ev)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            TRAIN_CNT <= '0;
            timer     <= '0;
            hold      <= '0;
            gate_ok   <= 1'b0;
            SW1       <= 1'b0;
            LED3      <= 1'b0;
        end else begin
            state     <= state_d;
            TRAIN_CNT <= cnt_d;
            timer     <= timer_d;
            hold      <= hold_d;
            gate_ok   <= gate_ok_d;
            SW1       <= (state_d != ST_IDLE);
            LED3      <= (state_d == ST_FAULT);
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = TRAIN_CNT;
        timer_d   = timer;
        hold_d    = hold;
        gate_ok_d = gate_ok;

        // Overflow or a stray exit; simultaneous entry+exit cancel out.
        fault_ev = (entry_ev && !exit_ev && (TRAIN_CNT == CNT_MAX)) ||
                   (exit_ev && !entry_ev && (TRAIN_CNT == '0));

        if ((state != ST_FAULT) && !fault_ev) begin
            if (entry_ev && !exit_ev) begin
                cnt_d = TRAIN_CNT + CNT_W'(1);
            end else if (exit_ev && !entry_ev) begin
                cnt_d = TRAIN_CNT - CNT_W'(1);
            end
        end

        case (state)
            ST_IDLE: begin
                if (fault_ev) begin
                    state_d = ST_FAULT;
                end else if (entry_ev) begin
                    state_d   = ST_OCCUPIED;
                    timer_d   = '0;
                    gate_ok_d = GATE_CLOSED;
                end
            end
            ST_OCCUPIED: begin
                if (fault_ev) begin
                    state_d = ST_FAULT;
                end else if (cnt_d == '0) begin
                    state_d = ST_CLEARING;
                    hold_d  = '0;
                end else if (!gate_ok) begin
                    // Gate-down feedback freezes the timeout for this occupancy.
                    if (GATE_CLOSED) begin
                        gate_ok_d = 1'b1;
                    end else if (timer == TO_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
            end
            ST_CLEARING: begin
                if (fault_ev) begin
                    state_d = ST_FAULT;
                end else if (entry_ev) begin
                    state_d   = ST_OCCUPIED;
                    timer_d   = '0;
                    gate_ok_d = GATE_CLOSED;
                end else if (hold == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold + HW'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

endmodule
